// File: rtl/if_id_reg_pkg.sv
// Shared constants and payload type for the fetch/decode pipeline register.
//   XLEN / EXC_W   : datapath and exception-code widths
//   EXC_NONE/ADEL  : exception codes carried into decode
//   PC_RESET       : lowest legal fetch address, also the PC reset value
//   IM_TOP_ADDR    : highest legal word-aligned fetch address
//   NOP            : instruction encoding used for bubbles and faulted fetches
package if_id_reg_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned EXC_W = 5;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

  localparam logic [XLEN-1:0] PC_RESET    = 32'h0000_3000;
  localparam logic [XLEN-1:0] IM_TOP_ADDR = 32'h0000_6FFC;
  localparam logic [XLEN-1:0] NOP         = 32'h0000_0000;

  // Everything the decode stage receives from this register.
  typedef struct packed {
    logic [XLEN-1:0]  instr;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc8;
    logic [EXC_W-1:0] exc_code;
    logic             bd;
    logic             valid;
  } id_payload_t;

endpackage

// File: rtl/if_id_reg_if.sv
// Bundle between fetch/hazard logic and the IF/ID register.
//   master : drives fetch values, Br_D and Stall_D/Flush_D; observes D outputs
//   slave  : the register itself
interface if_id_reg_if;
  import if_id_reg_pkg::*;

  logic [XLEN-1:0]  Instr_F;
  logic [XLEN-1:0]  PC_F;
  logic [XLEN-1:0]  PC8_F;
  logic             Br_D;
  logic             Stall_D;
  logic             Flush_D;

  logic [XLEN-1:0]  Instr_D;
  logic [XLEN-1:0]  PC_D;
  logic [XLEN-1:0]  PC8_D;
  logic [EXC_W-1:0] ExcCode_D;
  logic             BD_D;
  logic             Valid_D;

  modport master (
    output Instr_F, PC_F, PC8_F, Br_D, Stall_D, Flush_D,
    input  Instr_D, PC_D, PC8_D, ExcCode_D, BD_D, Valid_D
  );

  modport slave (
    input  Instr_F, PC_F, PC8_F, Br_D, Stall_D, Flush_D,
    output Instr_D, PC_D, PC8_D, ExcCode_D, BD_D, Valid_D
  );

endinterface

// File: rtl/if_id_reg_fetch_exc_check.sv
// Combinational fetch-address check; flags AdEL for a misaligned PC or one
// outside [IM_BASE, IM_TOP]. Shared with the fetch-side exception unit.
//   PC_F   in  : current fetch PC
//   AdEL_F out : address error on instruction fetch
module fetch_exc_check
  import if_id_reg_pkg::*;
#(
  parameter logic [XLEN-1:0] IM_BASE = PC_RESET,
  parameter logic [XLEN-1:0] IM_TOP  = IM_TOP_ADDR
) (
  input  logic [XLEN-1:0] PC_F,
  output logic            AdEL_F
);

  always_comb begin
    AdEL_F = (PC_F[1:0] != 2'b00) || (PC_F < IM_BASE) || (PC_F > IM_TOP);
  end

endmodule

// File: rtl/if_id_reg.sv
// Fetch/decode pipeline register. Captures instruction, PC and PC+8 from
// fetch, tags AdEL and delay-slot status, and honours stall/flush.
//   Clk    in : clock, rising edge
//   Rst    in : synchronous active-high reset
//   id_bus    : slave side of if_id_reg_if (F-stage inputs, D-stage outputs)
// Priority on each edge: Rst > Flush_D > Stall_D > advance.
module if_id_reg
  import if_id_reg_pkg::*;
#(
  parameter logic [XLEN-1:0] IM_BASE = PC_RESET,
  parameter logic [XLEN-1:0] IM_TOP  = IM_TOP_ADDR
) (
  input  logic         Clk,
  input  logic         Rst,
  if_id_reg_if.slave   id_bus
);

  localparam id_payload_t RESET_VAL = '{
    instr:    NOP,
    pc:       IM_BASE,
    pc8:      XLEN'(IM_BASE + 32'd8),
    exc_code: EXC_NONE,
    bd:       1'b0,
    valid:    1'b0
  };

  logic        adel_f;
  id_payload_t state_q;
  id_payload_t state_d;

  fetch_exc_check #(
    .IM_BASE (IM_BASE),
    .IM_TOP  (IM_TOP)
  ) u_fetch_exc_check (
    .PC_F   (id_bus.PC_F),
    .AdEL_F (adel_f)
  );

  // Next-state selection; hold is the default so stall needs no branch.
  always_comb begin
    state_d = state_q;
    if (id_bus.Flush_D) begin
      // Bubble still carries the fetch PC so CP0 has a usable EPC candidate.
      state_d.instr    = NOP;
      state_d.pc       = id_bus.PC_F;
      state_d.pc8      = id_bus.PC8_F;
      state_d.exc_code = EXC_NONE;
      state_d.bd       = 1'b0;
      state_d.valid    = 1'b0;
    end else if (!id_bus.Stall_D) begin
      // Faulted fetch is forced to nop; Instr_F may be garbage in that case.
      state_d.instr    = adel_f ? NOP : id_bus.Instr_F;
      state_d.pc       = id_bus.PC_F;
      state_d.pc8      = id_bus.PC8_F;
      state_d.exc_code = adel_f ? EXC_ADEL : EXC_NONE;
      // Br_D describes the instruction leaving D, so the newcomer is its slot.
      state_d.bd       = id_bus.Br_D;
      state_d.valid    = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= RESET_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign id_bus.Instr_D   = state_q.instr;
  assign id_bus.PC_D      = state_q.pc;
  assign id_bus.PC8_D     = state_q.pc8;
  assign id_bus.ExcCode_D = state_q.exc_code;
  assign id_bus.BD_D      = state_q.bd;
  assign id_bus.Valid_D   = state_q.valid;

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: directed cases with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_if_id_reg;
  import if_id_reg_pkg::*;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  if_id_reg_if bus ();

  if_id_reg dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .id_bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_adel(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
  endfunction

  // Behavioural model: what D must hold after each edge.
  logic [31:0] m_instr, m_pc, m_pc8;
  logic [4:0]  m_exc;
  logic        m_bd, m_valid;
  logic        m_known = 1'b0;

  always @(posedge Clk) begin
    if (Rst) begin
      m_instr <= 32'h0; m_pc <= 32'h3000; m_pc8 <= 32'h3008;
      m_exc <= 5'd0; m_bd <= 1'b0; m_valid <= 1'b0; m_known <= 1'b1;
    end else if (bus.Flush_D) begin
      m_instr <= 32'h0; m_pc <= bus.PC_F; m_pc8 <= bus.PC8_F;
      m_exc <= 5'd0; m_bd <= 1'b0; m_valid <= 1'b0;
    end else if (!bus.Stall_D) begin
      m_instr <= is_adel(bus.PC_F) ? 32'h0 : bus.Instr_F;
      m_pc <= bus.PC_F; m_pc8 <= bus.PC8_F;
      m_exc <= is_adel(bus.PC_F) ? 5'd4 : 5'd0;
      m_bd <= bus.Br_D; m_valid <= 1'b1;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge Clk) begin
    if (m_known) begin
      chk("m_instr", bus.Instr_D, m_instr);
      chk("m_pc",    bus.PC_D, m_pc);
      chk("m_pc8",   bus.PC8_D, m_pc8);
      chk("m_exc",   32'(bus.ExcCode_D), 32'(m_exc));
      chk("m_bd",    32'(bus.BD_D), 32'(m_bd));
      chk("m_valid", 32'(bus.Valid_D), 32'(m_valid));
    end
  end

  // Apply inputs for one edge, then return just after it.
  task automatic cyc(input logic rst, input logic flush, input logic stall, input logic br,
                     input logic [31:0] pc, input logic [31:0] pc8, input logic [31:0] instr);
    Rst          = rst;
    bus.Flush_D  = flush;
    bus.Stall_D  = stall;
    bus.Br_D     = br;
    bus.PC_F     = pc;
    bus.PC8_F    = pc8;
    bus.Instr_F  = instr;
    @(posedge Clk);
    #2;
  endtask

  task automatic adv(input logic br, input logic [31:0] pc, input logic [31:0] instr);
    cyc(1'b0, 1'b0, 1'b0, br, pc, pc + 32'd8, instr);
  endtask

  logic [31:0] bounds [6];
  logic [31:0] pc_r, pc8_r;
  int          sel;

  initial begin
    bounds[0] = 32'h0000_2FFC; bounds[1] = 32'h0000_3000; bounds[2] = 32'h0000_6FFC;
    bounds[3] = 32'h0000_7000; bounds[4] = 32'h0000_6FFE; bounds[5] = 32'hFFFF_FFFC;
    bus.Flush_D = 1'b0; bus.Stall_D = 1'b0; bus.Br_D = 1'b0;
    bus.PC_F = 32'h0; bus.PC8_F = 32'h0; bus.Instr_F = 32'h0;
    @(posedge Clk);
    #2;

    // Reset
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h3000, 32'h3008, 32'h0);
    chk("rst_instr", bus.Instr_D, 32'h0);
    chk("rst_pc",    bus.PC_D, 32'h3000);
    chk("rst_pc8",   bus.PC8_D, 32'h3008);
    chk("rst_valid", 32'(bus.Valid_D), 32'd0);
    chk("rst_bd",    32'(bus.BD_D), 32'd0);
    chk("rst_exc",   32'(bus.ExcCode_D), 32'd0);

    // Advance
    adv(1'b0, 32'h3004, 32'h3C01_1234);
    chk("adv_instr", bus.Instr_D, 32'h3C01_1234);
    chk("adv_pc",    bus.PC_D, 32'h3004);
    chk("adv_pc8",   bus.PC8_D, 32'h300C);
    chk("adv_valid", 32'(bus.Valid_D), 32'd1);
    chk("adv_exc",   32'(bus.ExcCode_D), 32'd0);

    // Delay slot: beq sits in D, Br_D high while the slot instruction advances
    adv(1'b0, 32'h300C, 32'h1000_0003);
    adv(1'b1, 32'h3010, 32'h2401_0001);
    chk("bd_pc",  bus.PC_D, 32'h3010);
    chk("bd_set", 32'(bus.BD_D), 32'd1);
    adv(1'b0, 32'h3014, 32'h2402_0002);
    chk("bd_clr", 32'(bus.BD_D), 32'd0);

    // Stall three cycles with changing inputs and Br_D high: all held
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h4000 + 32'(i * 4), 32'h4008, 32'hDEAD_0000 + 32'(i));
      chk("stall_pc",    bus.PC_D, 32'h3014);
      chk("stall_instr", bus.Instr_D, 32'h2402_0002);
      chk("stall_bd",    32'(bus.BD_D), 32'd0);
      chk("stall_valid", 32'(bus.Valid_D), 32'd1);
    end

    // Flush with stall: flush wins
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h3020, 32'h3028, 32'h1234_5678);
    chk("fl_instr", bus.Instr_D, 32'h0);
    chk("fl_valid", 32'(bus.Valid_D), 32'd0);
    chk("fl_pc",    bus.PC_D, 32'h3020);
    chk("fl_bd",    32'(bus.BD_D), 32'd0);

    // AdEL misaligned, garbage instruction
    adv(1'b0, 32'h3002, $urandom);
    chk("mis_instr", bus.Instr_D, 32'h0);
    chk("mis_exc",   32'(bus.ExcCode_D), 32'd4);
    chk("mis_valid", 32'(bus.Valid_D), 32'd1);

    // Range bounds
    adv(1'b0, 32'h2FFC, 32'hAAAA_5555);
    chk("lo_exc", 32'(bus.ExcCode_D), 32'd4);
    adv(1'b0, 32'h6FFC, 32'hAAAA_5555);
    chk("top_exc",   32'(bus.ExcCode_D), 32'd0);
    chk("top_instr", bus.Instr_D, 32'hAAAA_5555);
    adv(1'b0, 32'h7000, 32'hAAAA_5555);
    chk("hi_exc",   32'(bus.ExcCode_D), 32'd4);
    chk("hi_instr", bus.Instr_D, 32'h0);

    // Reset wins over flush and stall
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h5000, 32'h5008, 32'h1111_1111);
    chk("rst2_pc",    bus.PC_D, 32'h3000);
    chk("rst2_pc8",   bus.PC8_D, 32'h3008);
    chk("rst2_valid", 32'(bus.Valid_D), 32'd0);

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 2000; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6)       pc_r = 32'h3000 + 32'($urandom_range(0, 32'hFFF)) * 32'd4;
      else if (sel == 6) pc_r = 32'h3000 + 32'($urandom_range(0, 32'h3FFF));
      else if (sel == 7) pc_r = bounds[$urandom_range(0, 5)];
      else               pc_r = $urandom;
      pc8_r = ($urandom_range(0, 7) == 0) ? $urandom : pc_r + 32'd8;
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) == 0), 1'($urandom), pc_r, pc8_r, $urandom);
    end

    @(posedge Clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_reg.md
# if_id_reg

Fetch/decode pipeline register sitting directly downstream of the fetch unit. It captures the fetched instruction, PC and PC+8 each cycle and presents them to the decode stage. It also:
- tags fetch-address exceptions (AdEL) and branch-delay-slot status;
- tracks a valid bit;
- honours stall (hold) and flush (bubble) requests from the hazard and exception logic.

## Interface
Parameters:
- IM_BASE, 32'h0000_3000, lowest legal fetch address and PC reset value.
- IM_TOP, 32'h0000_6FFC, highest legal word-aligned fetch address.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  reset, synchronous, active-high.
- Instr_F  input  32  instruction from instruction memory at PC_F.
- PC_F  input  32  current fetch PC.
- PC8_F  input  32  PC_F+8 from next-PC logic.
- Br_D  input  1  decode says the instruction now held in D is a branch/jump.
- Stall_D  input  1  hold all D-stage state this cycle.
- Flush_D  input  1  replace D-stage contents with a bubble (exception, interrupt, eret).
- Instr_D  output  32  registered instruction; 0 (nop) on bubble or AdEL.
- PC_D  output  32  registered PC.
- PC8_D  output  32  registered PC+8.
- ExcCode_D  output  5  exception code; 0 = none, 4 = AdEL.
- BD_D  output  1  held instruction is in a branch delay slot.
- Valid_D  output  1  D holds a real instruction, not a bubble.

## Operation
- Fetch check is combinational on PC_F. AdEL_F = (PC_F[1:0] != 0) or (PC_F < IM_BASE) or (PC_F > IM_TOP).
- Normal advance (no Rst, no Flush_D, no Stall_D):
  - Instr_D <= AdEL_F ? 0 : Instr_F
  - PC_D <= PC_F; PC8_D <= PC8_F
  - ExcCode_D <= AdEL_F ? 4 : 0
  - BD_D <= Br_D (evaluated on the instruction currently in D, before it leaves)
  - Valid_D <= 1
- Stall: every output holds its value, including BD_D and ExcCode_D.
- Flush:
  - Instr_D <= 0; ExcCode_D <= 0; BD_D <= 0; Valid_D <= 0
  - PC_D <= PC_F; PC8_D <= PC8_F. The bubble carries the PC so CP0 always sees a sensible EPC candidate.
- Priority: Rst > Flush_D > Stall_D > advance.
- PC_D/PC8_D are pass-through; no arithmetic is performed here and there is no width change.

## Timing
- Latency one cycle: F-stage values at edge n appear on the D outputs after edge n.
- Reset values (after the Rst edge):
  - Instr_D = 0, PC_D = IM_BASE, PC8_D = IM_BASE+8
  - ExcCode_D = 0, BD_D = 0, Valid_D = 0
- Rst mid-stall or mid-flush: reset wins and the register reaches the reset values on that edge.
- Flush and stall asserted together: flush wins, and a bubble is loaded.
- Stall persisting N cycles: outputs are constant for N cycles. On the first non-stall edge the register advances using the PC_F/Instr_F/Br_D present at that edge.
- Br_D sampled during a stall is ignored. BD tagging happens only on the advancing edge.
- AdEL with misaligned PC: Instr_D = 0 regardless of Instr_F (which may be X from the memory model).
- PC_F = IM_TOP is legal. PC_F = IM_TOP+4 raises AdEL.
- No handshake: the upstream fetch unit must itself stop updating its PC when Stall_D = 1. This block does not gate the upstream PC.

## Structure
- Shared macro package (MACRO.v) holds:
  - `EXC_NONE 5'd0, `EXC_ADEL 5'd4
  - `PC_RESET 32'h0000_3000, `IM_TOP 32'h0000_6FFC
  - the nop encoding 32'h0
- One sub-module, fetch_exc_check: combinational, input PC_F, output AdEL_F. It is reused by the later fetch-side exception unit.
- All state lives in a single always block on posedge Clk.

## Test plan
- Reset: Rst = 1 one cycle → Instr_D = 0, PC_D = 32'h3000, PC8_D = 32'h3008, Valid_D = 0, BD_D = 0, ExcCode_D = 0.
- Advance: PC_F = 32'h3004, Instr_F = 32'h3C01_1234, no stall/flush → next cycle Instr_D = 32'h3C01_1234, PC_D = 32'h3004, Valid_D = 1, ExcCode_D = 0.
- Delay slot: D holds a beq with Br_D = 1, PC_F = 32'h3010 → next cycle PC_D = 32'h3010, BD_D = 1. The following advance with Br_D = 0 gives BD_D = 0.
- Stall then flush priority:
  - Stall_D = 1 for 3 cycles → outputs unchanged.
  - Stall_D = 1 with Flush_D = 1 → Instr_D = 0, Valid_D = 0, PC_D = PC_F.
- AdEL, misaligned: PC_F = 32'h3002, Instr_F = X → Instr_D = 0, ExcCode_D = 4, Valid_D = 1.
- AdEL, range bounds:
  - PC_F = 32'h2FFC → ExcCode_D = 4.
  - PC_F = 32'h6FFC → ExcCode_D = 0.
  - PC_F = 32'h7000 → ExcCode_D = 4.
